// File: rtl/trdb_pkg.sv
// trdb_pkg: shared constants and types for the trace debugger capture path.
//   XLEN              - default packet word width
//   DROPCNTLEN        - width of the saturating dropped-word counter
//   trdb_buf_state_e  - word buffer FSM states
//   trdb_buf_entry_t  - one buffer entry: overflow-marker flag plus data word
//   drop_cnt_inc      - saturating increment for the drop counter
package trdb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DROPCNTLEN = 16;

    typedef enum logic {
        BUF_RUN,
        BUF_DROP
    } trdb_buf_state_e;

    typedef struct packed {
        logic            marker;
        logic [XLEN-1:0] data;
    } trdb_buf_entry_t;

    // Counter sticks at all-ones so a long overflow still reports "at least max".
    function automatic logic [DROPCNTLEN-1:0] drop_cnt_inc(input logic [DROPCNTLEN-1:0] v);
        return (v == '1) ? v : v + DROPCNTLEN'(1);
    endfunction

endpackage

// File: rtl/trdb_fifo.sv
// trdb_fifo: generic synchronous first-word-fall-through FIFO.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset / flush
//   push_i  - write data_i (ignored when full)
//   data_i  - write data
//   pop_i   - discard head entry (ignored when empty)
//   head_o  - head entry, driven from storage; zero when empty
//   count_o - number of stored entries (0..DEPTH)
module trdb_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Head is read straight from storage; a write never targets the head slot
    // while it is occupied, so it stays stable until popped.
    assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/trdb_word_buffer.sv
// trdb_word_buffer: non-stallable capture buffer behind the trace debugger.
// Absorbs packet words into a FIFO, drains them over valid/ready, and on
// overflow drops words, counts them and inserts a tagged marker entry.
//   clk_i, rst_i          - clock, synchronous active-high reset
//   enable_i              - capture enable (ignored words are not counted)
//   clear_i               - synchronous flush, same effect as reset
//   packet_word_i/_valid_i- incoming word stream, no backpressure
//   out_data_o/_marker_o  - head entry data and marker flag
//   out_valid_o/ready_i   - head handshake
//   fill_level_o          - stored entry count
//   overflow_o            - sticky, set on the first dropped word
module trdb_word_buffer import trdb_pkg::*; #(
    parameter int unsigned XLEN  = trdb_pkg::XLEN,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] packet_word_i,
    input  logic            packet_word_valid_i,
    output logic [XLEN-1:0] out_data_o,
    output logic            out_marker_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [AW:0]     fill_level_o,
    output logic            overflow_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    trdb_buf_state_e        state_q;
    logic [DROPCNTLEN-1:0]  drop_cnt_q;
    logic                   overflow_q;

    logic                   flush;
    logic                   word_qual;
    logic                   full;
    logic [DROPCNTLEN-1:0]  drop_cnt_d;
    logic                   fifo_push;
    logic [XLEN:0]          fifo_wdata;
    logic [XLEN:0]          fifo_head;
    logic [AW:0]            fifo_count;
    logic                   fifo_pop;

    assign flush     = rst_i | clear_i;
    assign word_qual = enable_i & packet_word_valid_i;
    // Full looks at the registered count only; a same-cycle pop does not help.
    assign full      = (fifo_count == FULL_CNT);

    always_comb begin
        drop_cnt_d = word_qual ? drop_cnt_inc(drop_cnt_q) : drop_cnt_q;
        fifo_push  = 1'b0;
        fifo_wdata = {1'b0, packet_word_i};
        unique case (state_q)
            BUF_RUN: begin
                fifo_push = word_qual && !full;
            end
            BUF_DROP: begin
                // Marker count includes a word dropped in this same cycle.
                fifo_push  = !full;
                fifo_wdata = {1'b1, XLEN'(drop_cnt_d)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q    <= BUF_RUN;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                BUF_RUN: begin
                    if (word_qual && full) begin
                        state_q    <= BUF_DROP;
                        drop_cnt_q <= DROPCNTLEN'(1);
                        overflow_q <= 1'b1;
                    end
                end
                BUF_DROP: begin
                    if (!full) begin
                        state_q    <= BUF_RUN;
                        drop_cnt_q <= '0;
                    end else begin
                        drop_cnt_q <= drop_cnt_d;
                    end
                end
                default: state_q <= BUF_RUN;
            endcase
        end
    end

    assign fifo_pop = out_valid_o & out_ready_i;

    trdb_fifo #(
        .WIDTH (XLEN + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (flush),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign out_valid_o  = (fifo_count != '0);
    assign out_data_o   = fifo_head[XLEN-1:0];
    assign out_marker_o = fifo_head[XLEN];
    assign fill_level_o = fifo_count;
    assign overflow_o   = overflow_q;

endmodule
